// File: rtl/turf_rxclk_pkg.sv
// ============================================================================
// turf_rxclk_pkg : RXCLK sequencer state encoding and phase constants
// Rev 1.0
// ============================================================================
`default_nettype none

package turf_rxclk_pkg;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_LOCK_WAIT = 3'd1,
      ST_IDLE      = 3'd2,
      ST_PS_EN     = 3'd3,
      ST_PS_WAIT   = 3'd4
   } rxclk_ctrl_state_t;

   // 8 VCO periods x 56 fine steps per RXCLK period
   localparam int RXCLK_PS_STEPS = 448;
   localparam int RXCLK_PHASE_W  = 9;

endpackage

`default_nettype wire

// File: rtl/rxclk_lock_sync.sv
// ============================================================================
// rxclk_lock_sync : 2-FF synchronizer for the MMCM LOCKED output
// Rev 1.0
// ============================================================================
`default_nettype none

module rxclk_lock_sync (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_i,
   output logic sync_o
);

   (* ASYNC_REG = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE" *) logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/turf_rxclk_ctrl.sv
// ============================================================================
// turf_rxclk_ctrl : RXCLK MMCM reset/lock bring-up and fine phase-shift sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module turf_rxclk_ctrl
   import turf_rxclk_pkg::*;
#(
   parameter int RST_CYCLES         = 64,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int PS_TIMEOUT         = 64,
   parameter int PS_STEPS_PER_CYCLE = RXCLK_PS_STEPS,
   parameter     AUTO_RELOCK        = "TRUE"
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     reset_req_i,
   input  logic                     ps_req_i,
   input  logic [15:0]              ps_steps_i,
   output logic                     ps_ack_o,
   input  logic                     err_clr_i,
   output logic                     mmcm_rst_o,
   input  logic                     mmcm_locked_i,
   output logic                     ps_en_o,
   input  logic                     ps_done_i,
   output logic                     ready_o,
   output logic                     busy_o,
   output logic [RXCLK_PHASE_W-1:0] phase_o,
   output logic                     lock_err_o,
   output logic                     ps_err_o
);

   localparam bit AUTO_RELOCK_EN = (AUTO_RELOCK == "TRUE");

   localparam int TIMER_MAX_A = (RST_CYCLES > PS_TIMEOUT) ? RST_CYCLES : PS_TIMEOUT;
   localparam int TIMER_MAX   = (LOCK_TIMEOUT > TIMER_MAX_A) ? LOCK_TIMEOUT : TIMER_MAX_A;
   localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

   localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] PS_LAST   = TIMER_W'(PS_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

   localparam logic [RXCLK_PHASE_W-1:0] PHASE_LAST = RXCLK_PHASE_W'(PS_STEPS_PER_CYCLE - 1);
   localparam logic [RXCLK_PHASE_W-1:0] PHASE_ONE  = RXCLK_PHASE_W'(1);

   rxclk_ctrl_state_t          state_q, state_d;
   logic [TIMER_W-1:0]         timer_q, timer_d;
   logic [15:0]                remaining_q, remaining_d;
   logic [RXCLK_PHASE_W-1:0]   phase_q, phase_d;
   logic                       ps_ack_q, ps_ack_d;
   logic                       lock_err_q, lock_err_d;
   logic                       ps_err_q, ps_err_d;
   logic                       locked_s;

   rxclk_lock_sync u_lock_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .async_i (mmcm_locked_i),
      .sync_o  (locked_s)
   );

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      ps_ack_d    = 1'b0;
      // Clear is applied first so a same-cycle set below takes precedence
      lock_err_d  = lock_err_q & ~err_clr_i;
      ps_err_d    = ps_err_q & ~err_clr_i;

      case (state_q)
         ST_RESET: begin
            phase_d = '0;
            if (timer_q == RST_LAST) begin
               state_d = ST_LOCK_WAIT;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         ST_LOCK_WAIT: begin
            if (locked_s) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (timer_q == LOCK_LAST) begin
               lock_err_d = 1'b1;
               state_d    = ST_RESET;
               timer_d    = '0;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         ST_IDLE: begin
            if (reset_req_i) begin
               state_d = ST_RESET;
               timer_d = '0;
            end else if (!locked_s) begin
               lock_err_d = 1'b1;
               if (AUTO_RELOCK_EN) begin
                  state_d = ST_RESET;
                  timer_d = '0;
               end
            end else if (ps_req_i) begin
               remaining_d = ps_steps_i;
               if (ps_steps_i == 16'd0) begin
                  ps_ack_d = 1'b1;
               end else begin
                  state_d = ST_PS_EN;
               end
            end
         end

         ST_PS_EN: begin
            timer_d = '0;
            state_d = ST_PS_WAIT;
         end

         ST_PS_WAIT: begin
            if (ps_done_i) begin
               phase_d     = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_ONE;
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  ps_ack_d = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_PS_EN;
               end
            end else if (timer_q == PS_LAST) begin
               ps_err_d = 1'b1;
               ps_ack_d = 1'b1;
               state_d  = ST_RESET;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end

         default: begin
            state_d = ST_RESET;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_RESET;
         timer_q     <= '0;
         remaining_q <= '0;
         phase_q     <= '0;
         ps_ack_q    <= 1'b0;
         lock_err_q  <= 1'b0;
         ps_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         phase_q     <= phase_d;
         ps_ack_q    <= ps_ack_d;
         lock_err_q  <= lock_err_d;
         ps_err_q    <= ps_err_d;
      end
   end

   assign mmcm_rst_o = (state_q == ST_RESET);
   assign ps_en_o    = (state_q == ST_PS_EN);
   assign busy_o     = (state_q == ST_PS_EN) || (state_q == ST_PS_WAIT);
   assign ready_o    = (state_q == ST_IDLE) && locked_s;
   assign ps_ack_o   = ps_ack_q;
   assign phase_o    = phase_q;
   assign lock_err_o = lock_err_q;
   assign ps_err_o   = ps_err_q;

endmodule

`default_nettype wire

// File: tb/tb_turf_rxclk_ctrl.sv
// ============================================================================
// tb_turf_rxclk_ctrl : MMCM behavioural model plus transaction-level phase model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_turf_rxclk_ctrl;

   localparam int LT    = 4096;
   localparam int STEPS = 448;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reset_req;
   logic        ps_req;
   logic [15:0] ps_steps;
   logic        ps_ack;
   logic        err_clr;
   logic        mmcm_rst;
   logic        mmcm_locked = 1'b0;
   logic        ps_en;
   logic        ps_done = 1'b0;
   logic        ready;
   logic        busy;
   logic [8:0]  phase;
   logic        lock_err;
   logic        ps_err;

   int n_vec = 0;
   int n_err = 0;

   int en_total = 0;
   int ack_total = 0;
   int en_dbl = 0;
   int done_cnt = 0;
   int lock_cnt = 0;
   bit en_prev = 1'b0;
   bit force_low = 1'b0;
   bit done_en = 1'b1;
   int model_phase = 0;

   turf_rxclk_ctrl #(
      .LOCK_TIMEOUT (LT)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .reset_req_i   (reset_req),
      .ps_req_i      (ps_req),
      .ps_steps_i    (ps_steps),
      .ps_ack_o      (ps_ack),
      .err_clr_i     (err_clr),
      .mmcm_rst_o    (mmcm_rst),
      .mmcm_locked_i (mmcm_locked),
      .ps_en_o       (ps_en),
      .ps_done_i     (ps_done),
      .ready_o       (ready),
      .busy_o        (busy),
      .phase_o       (phase),
      .lock_err_o    (lock_err),
      .ps_err_o      (ps_err)
   );

   always #5 clk = ~clk;

   // MMCM model: LOCKED 100 cycles after RST falls, PSDONE 12 cycles after PSEN
   always @(negedge clk) begin
      ps_done = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0 && done_en) ps_done = 1'b1;
      end
      if (ps_en === 1'b1) begin
         en_total++;
         done_cnt = 12;
         if (en_prev) en_dbl++;
      end
      en_prev = (ps_en === 1'b1);
      if (ps_ack === 1'b1) ack_total++;
      if (mmcm_rst === 1'b1 || force_low) begin
         mmcm_locked = 1'b0;
         lock_cnt    = 0;
      end else if (!mmcm_locked) begin
         lock_cnt++;
         if (lock_cnt == 100) mmcm_locked = 1'b1;
      end
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic int outv();
      return int'({mmcm_rst, ps_en, ps_ack, ready, busy, lock_err, ps_err, phase});
   endfunction

   localparam int RST_VEC = 32'h8000;

   task automatic wait_ready(input int budget, input string tag);
      int k = 0;
      while (!ready && k < budget) begin
         step();
         k++;
      end
      check_eq(tag, int'(ready), 1);
   endtask

   task automatic do_req(input int steps);
      int en0 = en_total;
      int ack0 = ack_total;
      int k = 0;
      ps_req   = 1'b1;
      ps_steps = steps[15:0];
      step();
      ps_req   = 1'b0;
      ps_steps = 16'($urandom);
      if (steps > 0) check_eq("psen_latency", int'(ps_en), 1);
      else           check_eq("ack_zero_steps", int'(ps_ack), 1);
      model_phase = (model_phase + steps) % STEPS;
      while (ack_total == ack0 && k < steps * 20 + 20) begin
         // requests while busy must be ignored
         ps_req   = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         ps_steps = 16'($urandom_range(1, 9));
         step();
         k++;
      end
      ps_req = 1'b0;
      repeat (3) step();
      check_eq("ack_count", ack_total - ack0, 1);
      check_eq("psen_count", en_total - en0, steps);
      check_eq("phase", int'(phase), model_phase);
      check_eq("idle_ready", int'({busy, ready}), 1);
   endtask

   initial begin
      int n;
      int en0;
      int ack0;
      int s;
      rst_n = 1'b0; reset_req = 1'b0; ps_req = 1'b0; ps_steps = '0; err_clr = 1'b0;
      repeat (5) step();
      check_eq("reset_vals", outv(), RST_VEC);

      @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (mmcm_rst) n++;
         else break;
      end
      check_eq("rst_hold", n, 64);

      n = 0;
      while (!mmcm_locked && n < 300) begin step(); n++; end
      check_eq("model_locked", int'(mmcm_locked), 1);
      n = 0;
      while (!ready && n < 20) begin step(); n++; end
      check_eq("lock_to_ready", int'(n >= 2 && n <= 4), 1);
      check_eq("phase_after_lock", int'(phase), 0);

      do_req(5);
      check_eq("phase_five", int'(phase), 5);

      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 4)) step();
         do_req($urandom_range(0, 12));
      end

      s = (445 - model_phase + STEPS) % STEPS;
      do_req(s);
      check_eq("phase_445", int'(phase), 445);
      do_req(5);
      check_eq("wrap_phase", int'(phase), 2);
      check_eq("wrap_no_err", int'({lock_err, ps_err}), 0);

      reset_req = 1'b1;
      step();
      reset_req = 1'b0;
      check_eq("reset_req_rst", int'(mmcm_rst), 1);
      model_phase = 0;
      wait_ready(400, "reset_req_relock");
      check_eq("reset_req_phase", int'(phase), 0);
      check_eq("reset_req_no_err", int'({lock_err, ps_err}), 0);

      do_req(3);

      // PSDONE never returns
      done_en = 1'b0;
      en0 = en_total;
      ack0 = ack_total;
      ps_req = 1'b1; ps_steps = 16'd3;
      step();
      ps_req = 1'b0;
      check_eq("to_psen", int'(ps_en), 1);
      n = 0;
      while (ack_total == ack0 && n < 200) begin step(); n++; end
      check_eq("to_delay", int'(n >= 64 && n <= 66), 1);
      check_eq("to_ps_err", int'(ps_err), 1);
      check_eq("to_mmcm_rst", int'(mmcm_rst), 1);
      check_eq("to_psen_count", en_total - en0, 1);
      step();
      check_eq("to_phase", int'(phase), 0);
      check_eq("to_ack_once", ack_total - ack0, 1);
      model_phase = 0;
      done_en = 1'b1;
      wait_ready(400, "to_relock");
      check_eq("ps_err_sticky", int'(ps_err), 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_eq("ps_err_clr", int'({lock_err, ps_err}), 0);

      do_req(4);

      // LOCKED lost while idle
      force_low = 1'b1;
      n = 0;
      while (!mmcm_rst && n < 20) begin step(); n++; end
      check_eq("lock_loss_rst", int'(mmcm_rst), 1);
      check_eq("lock_err_set", int'(lock_err), 1);
      n = 1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (mmcm_rst) n++;
         else break;
      end
      check_eq("retry_rst_hold", n, 64);
      n = 1;
      for (int i = 0; i < LT + 100; i++) begin
         step();
         if (!mmcm_rst) n++;
         else break;
      end
      check_eq("lock_wait_len", n, LT);
      check_eq("retry_rst_again", int'(mmcm_rst), 1);
      repeat (200) step();
      force_low = 1'b0;
      model_phase = 0;
      wait_ready(LT + 400, "relock_ready");
      check_eq("relock_phase", int'(phase), 0);
      check_eq("lock_err_sticky", int'(lock_err), 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_eq("lock_err_clr", int'(lock_err), 0);

      // asynchronous reset in the middle of a 10-step request
      en0 = en_total;
      ps_req = 1'b1; ps_steps = 16'd10;
      step();
      ps_req = 1'b0;
      n = 0;
      while (en_total - en0 < 3 && n < 200) begin step(); n++; end
      check_eq("mid_progress", en_total - en0, 3);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_rst_vals", outv(), RST_VEC);
      en0 = en_total;
      repeat (4) step();
      check_eq("held_rst_vals", outv(), RST_VEC);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (150) step();
      check_eq("no_psen_after_rst", en_total - en0, 0);
      model_phase = 0;
      wait_ready(400, "post_rst_ready");
      check_eq("post_rst_phase", int'(phase), 0);
      do_req(2);

      check_eq("psen_single_cycle", en_dbl, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/turf_rxclk_ctrl.md
# turf_rxclk_ctrl

Control sequencer for the TURF RXCLK MMCM. It sits directly upstream of the RXCLK clock generator and drives that block's `rst_i`, `ps_en_i` and PSCLK domain. It consumes `locked_o` and `ps_done_o` from the clock generator. It owns the MMCM reset/lock bring-up, issues multi-step fine phase-shift requests one MMCM step at a time, tracks the absolute phase position, and reports lock and timeout errors to the register interface.

## Interface
Parameters:
- `RST_CYCLES`, 64: cycles `mmcm_rst_o` is held high per reset attempt.
- `LOCK_TIMEOUT`, 65536: cycles allowed in LOCK_WAIT before a lock error.
- `PS_TIMEOUT`, 64: cycles allowed between `ps_en_o` and `ps_done_i`.
- `PS_STEPS_PER_CYCLE`, 448: fine steps per RXCLK period (8 VCO periods × 56); phase wrap modulus.
- `AUTO_RELOCK`, "TRUE": on lock loss in IDLE, re-enter RESET automatically.

Ports:
- `clk_i` in 1: control clock; also drives the MMCM PSCLK.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `reset_req_i` in 1: single-cycle request to re-run MMCM reset.
- `ps_req_i` in 1: phase-shift request; sampled only in IDLE.
- `ps_steps_i` in 16: number of increment steps; sampled with `ps_req_i`.
- `ps_ack_o` out 1: one-cycle pulse when the request completes or aborts.
- `err_clr_i` in 1: clears sticky error flags.
- `mmcm_rst_o` out 1: to MMCM RST.
- `mmcm_locked_i` in 1: MMCM LOCKED; asynchronous to `clk_i`.
- `ps_en_o` out 1: to MMCM PSEN; always a single-cycle pulse.
- `ps_done_i` in 1: MMCM PSDONE; synchronous to `clk_i`.
- `ready_o` out 1: state is IDLE and the synchronized lock is high.
- `busy_o` out 1: a phase-shift request is in progress.
- `phase_o` out 9: current phase position, 0..PS_STEPS_PER_CYCLE-1.
- `lock_err_o` out 1: sticky; set on lock timeout or lock loss.
- `ps_err_o` out 1: sticky; set on PSDONE timeout.

## Operation
- `mmcm_locked_i` passes through a 2-FF synchronizer before use, giving `locked_s`.
- States: RESET, LOCK_WAIT, IDLE, PS_EN, PS_WAIT.
- **RESET:**
  - `mmcm_rst_o`=1, timer counts RST_CYCLES.
  - `phase_o` is cleared to 0, because the MMCM phase is lost on reset.
  - Moves to LOCK_WAIT when the timer expires.
- **LOCK_WAIT:**
  - `mmcm_rst_o`=0.
  - `locked_s`=1 → IDLE.
  - Timer reaches LOCK_TIMEOUT → set `lock_err_o`, go to RESET (retry indefinitely).
- **IDLE:** priority order:
  1. `reset_req_i` → RESET.
  2. `locked_s`=0 → set `lock_err_o`. If AUTO_RELOCK, go to RESET; otherwise stay in IDLE with `ready_o`=0.
  3. `ps_req_i` → latch `ps_steps_i` into `remaining`. If `remaining`=0, pulse `ps_ack_o` next cycle and stay in IDLE; otherwise go to PS_EN.
- **PS_EN:** `ps_en_o`=1 for exactly one cycle, clear the timeout timer, go to PS_WAIT.
- **PS_WAIT:**
  - On `ps_done_i`:
    - `phase_o` ← (`phase_o`+1) mod PS_STEPS_PER_CYCLE, so 447 → 0.
    - `remaining` decrements.
    - If the new `remaining`=0 → pulse `ps_ack_o`, go to IDLE; otherwise go to PS_EN.
  - Timer reaches PS_TIMEOUT → set `ps_err_o`, pulse `ps_ack_o`, go to RESET.
- Phase shifts are increment-only; the downstream MMCM has PSINCDEC tied high.
- `ps_req_i`, `reset_req_i` and `ps_done_i` are ignored in states where they are not listed.
- `err_clr_i` clears both error flags. If an error set-condition occurs in the same cycle, the set wins.
- `busy_o` = state ∈ {PS_EN, PS_WAIT}.

## Timing
- Reset values while `rst_n_i`=0:
  - state RESET with timer at 0, so `mmcm_rst_o`=1 (the MMCM is held in reset).
  - `ps_en_o`=0, `ps_ack_o`=0, `ready_o`=0, `busy_o`=0, `phase_o`=0, both error flags 0.
- Request accepted at edge N (IDLE, `ps_req_i`=1) → `ps_en_o` high during cycle N+1 only.
- `ps_done_i` sampled at edge M:
  - `phase_o` is updated in cycle M+1.
  - `ps_en_o` is high in cycle M+1 if steps remain; otherwise `ps_ack_o` is high in cycle M+1.
- Per-step overhead: 2 cycles plus MMCM PSDONE latency (12 PSCLK).
- `locked_s` lags `mmcm_locked_i` by 2–3 cycles. IDLE is entered on the cycle after `locked_s` rises.
- `rst_n_i` asserted mid-shift: immediate return to reset values. The step count in progress is lost, and `phase_o` returns to 0.

## Structure
- Package `turf_rxclk_pkg`: state enum `rxclk_ctrl_state_t` and constant `RXCLK_PS_STEPS` (448), shared with the register map.
- Sub-module `rxclk_lock_sync`: 2-FF synchronizer with ASYNC_REG attributes, reset to 0.
- Everything else lives in one always_ff block with a single always_comb next-state block.

## Test plan
- Release reset; model asserts LOCKED 100 cycles after `mmcm_rst_o` falls → `mmcm_rst_o` high 64 cycles, then `ready_o`=1 about 3 cycles after LOCKED, `phase_o`=0.
- `ps_req_i` with `ps_steps_i`=5; model returns PSDONE 12 cycles after each PSEN → exactly 5 one-cycle `ps_en_o` pulses, one `ps_ack_o`, `phase_o`=5.
- Starting from `phase_o`=445, request 5 steps → `phase_o`=2 (wrap), no errors.
- Model never returns PSDONE → after 64 cycles: `ps_err_o`=1, `ps_ack_o` pulse, `mmcm_rst_o` reasserted, `phase_o`=0. Then `err_clr_i` → `ps_err_o`=0.
- Drop LOCKED while in IDLE with AUTO_RELOCK="TRUE" → `lock_err_o`=1 and the reset sequence reruns. Hold LOCKED low for 70000 cycles → repeated RESET/LOCK_WAIT retries.
- Assert `rst_n_i` in the middle of a 10-step request → all outputs return to reset values asynchronously, and no further `ps_en_o` pulses occur.
